// File: rtl/yuv_stream_pkg.sv
// yuv_stream_pkg: shared definitions for the YUYV 4:2:2 -> 4:4:4 chroma upsampler.
//   - byte offsets of the Y/U/V samples inside a packed 64-bit YUYV beat
//   - field offsets inside a 32-bit 4:4:4 pixel word
//   - upsampler FSM state type
//   - pack444(): builds one pixel word
package yuv_stream_pkg;

    // YUYV input beat: b0=Y0 b1=U0 b2=Y1 b3=V0 b4=Y2 b5=U1 b6=Y3 b7=V1
    localparam int unsigned IN_Y0_OFS = 0;
    localparam int unsigned IN_U0_OFS = 8;
    localparam int unsigned IN_Y1_OFS = 16;
    localparam int unsigned IN_V0_OFS = 24;
    localparam int unsigned IN_Y2_OFS = 32;
    localparam int unsigned IN_U1_OFS = 40;
    localparam int unsigned IN_Y3_OFS = 48;
    localparam int unsigned IN_V1_OFS = 56;

    // 4:4:4 pixel word: [7:0]=V [15:8]=U [23:16]=Y [31:24]=pad
    localparam int unsigned PIX_V_OFS   = 0;
    localparam int unsigned PIX_U_OFS   = 8;
    localparam int unsigned PIX_Y_OFS   = 16;
    localparam int unsigned PIX_PAD_OFS = 24;

    typedef enum logic [1:0] {EMPTY, FIRST, SECOND} upsamp_state_t;

    function automatic logic [31:0] pack444(input logic [7:0] y, input logic [7:0] u,
                                            input logic [7:0] v, input logic [7:0] pad);
        logic [31:0] w;
        w = '0;
        w[PIX_V_OFS   +: 8] = v;
        w[PIX_U_OFS   +: 8] = u;
        w[PIX_Y_OFS   +: 8] = y;
        w[PIX_PAD_OFS +: 8] = pad;
        return w;
    endfunction

endpackage

// File: rtl/yuv422to444_if.sv
// nasti_stream_channel: AXI-stream style channel bundle.
//   master modport drives valid/data/sideband and samples ready;
//   slave modport is the mirror image.
interface nasti_stream_channel #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned DEST_WIDTH = 1,
    parameter int unsigned ID_WIDTH   = 1
);
    logic                    t_valid;
    logic                    t_ready;
    logic [DATA_WIDTH-1:0]   t_data;
    logic [DATA_WIDTH/8-1:0] t_strb;
    logic [DATA_WIDTH/8-1:0] t_keep;
    logic                    t_last;
    logic [ID_WIDTH-1:0]     t_id;
    logic [DEST_WIDTH-1:0]   t_dest;
    logic [USER_WIDTH-1:0]   t_user;

    modport master (
        output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
        input  t_ready
    );

    modport slave (
        input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
        output t_ready
    );
endinterface

// File: rtl/yuv422to444.sv
// yuv422to444: nearest-neighbour chroma upsampler, YUYV 4:2:2 -> 4:4:4.
//   One 64-bit input beat (4 pixels) becomes two 64-bit output beats (2 pixels each).
// Ports:
//   aclk   - clock
//   areset - asynchronous active-high reset
//   src    - YUYV 4:2:2 input stream (slave)
//   dst    - 4:4:4 output stream (master), pixel word {pad, Y, U, V}
module yuv422to444
    import yuv_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned DEST_WIDTH = 1,
    parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
    input  logic                aclk,
    input  logic                areset,
    nasti_stream_channel.slave  src,
    nasti_stream_channel.master dst
);

    if (DATA_WIDTH != 64) begin : g_width_check
        $error("yuv422to444: only DATA_WIDTH = 64 is supported");
    end

    upsamp_state_t         state_q, state_d;
    logic [63:0]           data_q, data_d;
    logic                  last_q, last_d;
    logic                  half_q, half_d;
    logic [USER_WIDTH-1:0] user_q, user_d;
    logic [DEST_WIDTH-1:0] dest_q, dest_d;

    logic        src_hs;
    logic        capture;
    logic [63:0] beat_a, beat_b;

    assign beat_a = {pack444(data_q[IN_Y1_OFS +: 8], data_q[IN_U0_OFS +: 8],
                             data_q[IN_V0_OFS +: 8], PAD_BYTE),
                     pack444(data_q[IN_Y0_OFS +: 8], data_q[IN_U0_OFS +: 8],
                             data_q[IN_V0_OFS +: 8], PAD_BYTE)};
    assign beat_b = {pack444(data_q[IN_Y3_OFS +: 8], data_q[IN_U1_OFS +: 8],
                             data_q[IN_V1_OFS +: 8], PAD_BYTE),
                     pack444(data_q[IN_Y2_OFS +: 8], data_q[IN_U1_OFS +: 8],
                             data_q[IN_V1_OFS +: 8], PAD_BYTE)};

    assign src_hs = src.t_valid & src.t_ready;

    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        src.t_ready = 1'b0;
        dst.t_valid = 1'b0;
        dst.t_data  = '0;
        dst.t_last  = 1'b0;
        unique case (state_q)
            EMPTY: begin
                src.t_ready = 1'b1;
                if (src.t_valid) begin
                    capture = 1'b1;
                    state_d = FIRST;
                end
            end
            FIRST: begin
                dst.t_valid = 1'b1;
                dst.t_data  = beat_a;
                dst.t_last  = half_q & last_q;
                // A half beat ends here, so the slot can be refilled in the same cycle.
                src.t_ready = half_q & dst.t_ready;
                if (dst.t_ready) begin
                    if (!half_q) begin
                        state_d = SECOND;
                    end else if (src.t_valid) begin
                        capture = 1'b1;
                        state_d = FIRST;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            SECOND: begin
                dst.t_valid = 1'b1;
                dst.t_data  = beat_b;
                dst.t_last  = last_q;
                src.t_ready = dst.t_ready;
                if (dst.t_ready) begin
                    if (src.t_valid) begin
                        capture = 1'b1;
                        state_d = FIRST;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        data_d = data_q;
        last_d = last_q;
        half_d = half_q;
        user_d = user_q;
        dest_d = dest_q;
        if (capture) begin
            data_d = src.t_data;
            last_d = src.t_last;
            // Only 8'h0F is a half beat; any other keep pattern is treated as full.
            half_d = (src.t_keep == 8'h0F);
            user_d = src.t_user;
            dest_d = src.t_dest;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            last_q  <= 1'b0;
            half_q  <= 1'b0;
            user_q  <= '0;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            half_q  <= half_d;
            user_q  <= user_d;
            dest_q  <= dest_d;
        end
    end

    assign dst.t_user = user_q;
    assign dst.t_dest = dest_q;
    assign dst.t_keep = '1;
    assign dst.t_strb = '1;
    assign dst.t_id   = '0;

    logic unused_src;
    assign unused_src = ^{src.t_id, src.t_strb};

    a_legal_keep: assert property (@(posedge aclk) disable iff (areset)
        src_hs |-> (src.t_keep == 8'hFF || src.t_keep == 8'h0F) &&
                   (src.t_strb == 8'hFF || src.t_strb == 8'h0F))
        else $error("yuv422to444: illegal keep/strb pattern on input beat");

endmodule

// File: tb/tb_yuv422to444.sv
// tb_yuv422to444: directed self-checking bench for the YUYV 4:2:2 -> 4:4:4 upsampler.
module tb_yuv422to444;

    logic clk;
    logic rst;

    nasti_stream_channel #(.DATA_WIDTH(64)) src_if ();
    nasti_stream_channel #(.DATA_WIDTH(64)) dst_if ();

    yuv422to444 u_dut (
        .aclk   (clk),
        .areset (rst),
        .src    (src_if.slave),
        .dst    (dst_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] keep,
                         input logic last, input logic user, input logic dest);
        src_if.t_valid = v;
        src_if.t_data  = d;
        src_if.t_keep  = keep;
        src_if.t_strb  = keep;
        src_if.t_last  = last;
        src_if.t_user  = user;
        src_if.t_dest  = dest;
        src_if.t_id    = 1'b0;
    endtask

    // Hand-computed input beats and their two expected output beats.
    logic [63:0] in_tbl [4];
    logic [63:0] out_tbl [8];

    initial begin
        in_tbl[0]  = 64'h6040_7030_9020_8010;
        in_tbl[1]  = 64'h0807_0605_0403_0201;
        in_tbl[2]  = 64'hFF00_FF00_FF00_FF00;
        in_tbl[3]  = 64'h1122_3344_5566_7788;
        out_tbl[0] = 64'h0020_8090_0010_8090;
        out_tbl[1] = 64'h0040_7060_0030_7060;
        out_tbl[2] = 64'h0003_0204_0001_0204;
        out_tbl[3] = 64'h0007_0608_0005_0608;
        out_tbl[4] = 64'h0000_FFFF_0000_FFFF;
        out_tbl[5] = 64'h0000_FFFF_0000_FFFF;
        out_tbl[6] = 64'h0066_7755_0088_7755;
        out_tbl[7] = 64'h0022_3311_0044_3311;

        rst = 1'b1;
        dst_if.t_ready = 1'b1;
        drive(1'b0, '0, 8'hFF, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {63'd0, dst_if.t_valid}, 64'd0);
        chk("reset_last",  {63'd0, dst_if.t_last}, 64'd0);
        chk("reset_data",  dst_if.t_data, 64'd0);
        chk("reset_user",  {63'd0, dst_if.t_user}, 64'd0);
        chk("reset_dest",  {63'd0, dst_if.t_dest}, 64'd0);
        rst = 1'b0;
        tick();

        // Single full beat with last.
        drive(1'b1, in_tbl[0], 8'hFF, 1'b1, 1'b0, 1'b0);
        #1;
        chk("single_src_ready", {63'd0, src_if.t_ready}, 64'd1);
        tick();
        drive(1'b0, '0, 8'hFF, 1'b0, 1'b0, 1'b0);
        #1;
        chk("single_a_valid", {63'd0, dst_if.t_valid}, 64'd1);
        chk("single_a_data",  dst_if.t_data, out_tbl[0]);
        chk("single_a_last",  {63'd0, dst_if.t_last}, 64'd0);
        chk("single_a_ready", {63'd0, src_if.t_ready}, 64'd0);
        tick();
        chk("single_b_data",  dst_if.t_data, out_tbl[1]);
        chk("single_b_last",  {63'd0, dst_if.t_last}, 64'd1);
        tick();
        chk("single_idle",    {63'd0, dst_if.t_valid}, 64'd0);

        // Four back-to-back full beats: 8 continuous output beats.
        begin
            int nxt;
            nxt = 0;
            for (int c = 0; c < 9; c++) begin
                if (nxt < 4) drive(1'b1, in_tbl[nxt], 8'hFF, nxt == 3, 1'b0, 1'b0);
                else         drive(1'b0, '0, 8'hFF, 1'b0, 1'b0, 1'b0);
                #1;
                chk($sformatf("b2b_src_ready_%0d", c), {63'd0, src_if.t_ready},
                    {63'd0, c % 2 == 0});
                if (c >= 1) begin
                    chk($sformatf("b2b_valid_%0d", c), {63'd0, dst_if.t_valid}, 64'd1);
                    chk($sformatf("b2b_data_%0d", c), dst_if.t_data, out_tbl[c-1]);
                    chk($sformatf("b2b_last_%0d", c), {63'd0, dst_if.t_last},
                        {63'd0, c == 8});
                end
                if (src_if.t_valid && src_if.t_ready) nxt++;
                tick();
            end
            drive(1'b0, '0, 8'hFF, 1'b0, 1'b0, 1'b0);
            #1;
            chk("b2b_idle", {63'd0, dst_if.t_valid}, 64'd0);
        end

        // Half beat: single output beat carrying last, back to EMPTY.
        drive(1'b1, in_tbl[0], 8'h0F, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 8'hFF, 1'b0, 1'b0, 1'b0);
        #1;
        chk("half_data",  dst_if.t_data, out_tbl[0]);
        chk("half_last",  {63'd0, dst_if.t_last}, 64'd1);
        chk("half_ready", {63'd0, src_if.t_ready}, 64'd1);
        tick();
        chk("half_idle",  {63'd0, dst_if.t_valid}, 64'd0);

        // Half beat followed immediately by a full beat accepted in FIRST.
        drive(1'b1, in_tbl[0], 8'h0F, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, in_tbl[1], 8'hFF, 1'b0, 1'b0, 1'b0);
        #1;
        chk("half_refill_ready", {63'd0, src_if.t_ready}, 64'd1);
        tick();
        drive(1'b0, '0, 8'hFF, 1'b0, 1'b0, 1'b0);
        #1;
        chk("half_refill_a", dst_if.t_data, out_tbl[2]);
        tick();
        chk("half_refill_b", dst_if.t_data, out_tbl[3]);
        tick();

        // Backpressure in FIRST: beat A held, no input accepted.
        drive(1'b1, in_tbl[1], 8'hFF, 1'b1, 1'b0, 1'b0);
        tick();
        dst_if.t_ready = 1'b0;
        drive(1'b1, in_tbl[3], 8'hFF, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("stall_valid_%0d", c), {63'd0, dst_if.t_valid}, 64'd1);
            chk($sformatf("stall_data_%0d", c), dst_if.t_data, out_tbl[2]);
            chk($sformatf("stall_ready_%0d", c), {63'd0, src_if.t_ready}, 64'd0);
            tick();
        end
        drive(1'b0, '0, 8'hFF, 1'b0, 1'b0, 1'b0);
        dst_if.t_ready = 1'b1;
        #1;
        chk("stall_rel_a",    dst_if.t_data, out_tbl[2]);
        chk("stall_rel_a_lst", {63'd0, dst_if.t_last}, 64'd0);
        tick();
        chk("stall_rel_b",    dst_if.t_data, out_tbl[3]);
        chk("stall_rel_b_lst", {63'd0, dst_if.t_last}, 64'd1);
        tick();

        // Sideband pass-through on both output beats.
        drive(1'b1, in_tbl[2], 8'hFF, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, 8'hFF, 1'b0, 1'b0, 1'b0);
        #1;
        chk("side_a_user", {63'd0, dst_if.t_user}, 64'd1);
        chk("side_a_dest", {63'd0, dst_if.t_dest}, 64'd1);
        tick();
        chk("side_b_user", {63'd0, dst_if.t_user}, 64'd1);
        chk("side_b_dest", {63'd0, dst_if.t_dest}, 64'd1);
        chk("side_b_last", {63'd0, dst_if.t_last}, 64'd0);
        tick();

        // Reset while in SECOND, then a fresh beat.
        dst_if.t_ready = 1'b0;
        drive(1'b1, in_tbl[0], 8'hFF, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 8'hFF, 1'b0, 1'b0, 1'b0);
        dst_if.t_ready = 1'b1;
        tick();
        dst_if.t_ready = 1'b0;
        #1;
        chk("rst_mid_in_second", dst_if.t_data, out_tbl[1]);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {63'd0, dst_if.t_valid}, 64'd0);
        tick();
        chk("rst_mid_valid_edge", {63'd0, dst_if.t_valid}, 64'd0);
        rst = 1'b0;
        dst_if.t_ready = 1'b1;
        tick();
        chk("rst_after_idle", {63'd0, dst_if.t_valid}, 64'd0);
        drive(1'b1, in_tbl[2], 8'hFF, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 8'hFF, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_fresh_a",      dst_if.t_data, 64'h0000_FFFF_0000_FFFF);
        chk("rst_fresh_a_last", {63'd0, dst_if.t_last}, 64'd0);
        tick();
        chk("rst_fresh_b_last", {63'd0, dst_if.t_last}, 64'd1);
        tick();
        chk("rst_fresh_idle",   {63'd0, dst_if.t_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
